sap1_datapath: RTL and testbench

- Datapath responder for the SAP-1 controller: consumes the controller's control word each cycle and returns `opcode` and `flags` to it.
- Contains the 8-bit shared bus, program counter, MAR, 16x8 RAM, instruction register, A/B registers, adder/subtractor ALU, flags register and output register.
- Includes a program-load port so a bench or top level can preload RAM.

---
 rtl/sap1_datapath.sv | 153 +++++++++++++++
 tb/tb_sap1_datapath.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sap1_datapath.sv
// SAP-1 datapath: shared OR-bus, PC, MAR, 16x8 RAM, IR, A/B, add/sub ALU, flags, output register.
// The controller drives the control word each cycle; opcode and flags are returned to it.
`timescale 1ns/1ps
module sap1_datapath #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             halt,
    input  logic                             reg_a_in,
    input  logic                             reg_a_out,
    input  logic                             reg_b_in,
    input  logic                             reg_b_out,
    input  logic                             alu_out,
    input  logic                             alu_sub,
    input  logic                             instr_in,
    input  logic                             instr_out,
    input  logic                             mar_in,
    input  logic                             ram_in,
    input  logic                             ram_out,
    input  logic                             reg_out,
    input  logic                             pc_inc,
    input  logic                             pc_out,
    input  logic                             pc_jmp,
    input  logic [3:0]                       reg_flags_in,
    input  logic                             prog_we,
    input  logic [ADDR_WIDTH-1:0]            prog_addr,
    input  logic [DATA_WIDTH-1:0]            prog_data,
    output logic [DATA_WIDTH-ADDR_WIDTH-1:0] opcode,
    output logic [3:0]                       flags,
    output logic [DATA_WIDTH-1:0]            out_value,
    output logic                             out_valid,
    output logic [DATA_WIDTH-1:0]            bus,
    output logic [ADDR_WIDTH-1:0]            pc,
    output logic                             bus_conflict
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam int EXT_W = DATA_WIDTH - ADDR_WIDTH;

    logic [ADDR_WIDTH-1:0] pc_q, pc_d, mar_q, mar_d;
    logic [DATA_WIDTH-1:0] ir_q, ir_d, a_q, a_d, b_q, b_d;
    logic [DATA_WIDTH-1:0] out_value_q, out_value_d;
    logic                  out_valid_q, out_valid_d;
    logic [3:0]            flags_q, flags_d;

    logic [DATA_WIDTH-1:0] ram_mem [DEPTH];
    logic                  ram_we;
    logic [ADDR_WIDTH-1:0] ram_waddr;
    logic [DATA_WIDTH-1:0] ram_wdata;

    logic [DATA_WIDTH-1:0] b_op;
    logic [DATA_WIDTH:0]   alu_res;
    logic [3:0]            alu_flags;
    logic [2:0]            n_drv;

    // ALU always evaluates on current A/B so flags can load without driving the bus
    always_comb begin
        b_op      = alu_sub ? ~b_q : b_q;
        alu_res   = {1'b0, a_q} + {1'b0, b_op} + {{DATA_WIDTH{1'b0}}, alu_sub};
        alu_flags = {(a_q[DATA_WIDTH-1] == b_op[DATA_WIDTH-1]) &&
                         (alu_res[DATA_WIDTH-1] != a_q[DATA_WIDTH-1]),
                     alu_res[DATA_WIDTH-1],
                     alu_res[DATA_WIDTH-1:0] == '0,
                     alu_res[DATA_WIDTH]};
    end

    always_comb begin
        bus = '0;
        if (pc_out)    bus = bus | {{EXT_W{1'b0}}, pc_q};
        if (ram_out)   bus = bus | ram_mem[mar_q];
        if (reg_a_out) bus = bus | a_q;
        if (reg_b_out) bus = bus | b_q;
        if (alu_out)   bus = bus | alu_res[DATA_WIDTH-1:0];
        if (instr_out) bus = bus | {{EXT_W{1'b0}}, ir_q[ADDR_WIDTH-1:0]};
        n_drv = 3'(pc_out) + 3'(ram_out) + 3'(reg_a_out) + 3'(reg_b_out)
              + 3'(alu_out) + 3'(instr_out);
        bus_conflict = n_drv > 3'd1;
    end

    always_comb begin
        pc_d        = pc_q;
        mar_d       = mar_q;
        ir_d        = ir_q;
        a_d         = a_q;
        b_d         = b_q;
        flags_d     = flags_q;
        out_value_d = out_value_q;
        out_valid_d = 1'b0;
        if (!halt) begin
            if (pc_jmp)      pc_d = bus[ADDR_WIDTH-1:0];
            else if (pc_inc) pc_d = pc_q + ADDR_WIDTH'(1);
            if (mar_in)      mar_d = bus[ADDR_WIDTH-1:0];
            if (instr_in)    ir_d = bus;
            // a register driving the bus while loading keeps its old value
            if (reg_a_in && !reg_a_out) a_d = bus;
            if (reg_b_in && !reg_b_out) b_d = bus;
            for (int i = 0; i < 4; i++)
                if (reg_flags_in[i]) flags_d[i] = alu_flags[i];
            if (reg_out) begin
                out_value_d = bus;
                out_valid_d = 1'b1;
            end
        end
    end

    always_comb begin
        ram_we    = 1'b0;
        ram_waddr = mar_q;
        ram_wdata = bus;
        if (prog_we) begin
            ram_we    = 1'b1;
            ram_waddr = prog_addr;
            ram_wdata = prog_data;
        end else if (ram_in && !halt) begin
            ram_we = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (ram_we) ram_mem[ram_waddr] <= ram_wdata;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q        <= '0;
            mar_q       <= '0;
            ir_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            flags_q     <= '0;
            out_value_q <= '0;
            out_valid_q <= 1'b0;
        end else begin
            pc_q        <= pc_d;
            mar_q       <= mar_d;
            ir_q        <= ir_d;
            a_q         <= a_d;
            b_q         <= b_d;
            flags_q     <= flags_d;
            out_value_q <= out_value_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign opcode    = ir_q[DATA_WIDTH-1:ADDR_WIDTH];
    assign flags     = flags_q;
    assign out_value = out_value_q;
    assign out_valid = out_valid_q;
    assign pc        = pc_q;

endmodule

// File: tb/tb_sap1_datapath.sv
// Bench for sap1_datapath: stimulus queues hand-computed expectations, a monitor
// compares them at each falling edge (or on demand) and scores out_valid pulses.
`timescale 1ns/1ps
module tb_sap1_datapath;

    localparam int S_PC = 0, S_OPC = 1, S_FLG = 2, S_BUS = 3, S_OUTV = 4, S_OVLD = 5, S_CONF = 6;

    typedef struct {
        string      name;
        int         sel;
        logic [7:0] exp;
    } chk_t;

    chk_t       chk_q[$];
    logic [7:0] out_q[$];
    int         n_vec = 0;
    int         n_err = 0;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       achk = 1'b0;
    logic       halt, reg_a_in, reg_a_out, reg_b_in, reg_b_out, alu_out, alu_sub;
    logic       instr_in, instr_out, mar_in, ram_in, ram_out, reg_out;
    logic       pc_inc, pc_out, pc_jmp, prog_we;
    logic [3:0] reg_flags_in, prog_addr, opcode, flags, pc;
    logic [7:0] prog_data, out_value, bus;
    logic       out_valid, bus_conflict;

    sap1_datapath #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
        .clk(clk), .rst(rst), .halt(halt),
        .reg_a_in(reg_a_in), .reg_a_out(reg_a_out), .reg_b_in(reg_b_in), .reg_b_out(reg_b_out),
        .alu_out(alu_out), .alu_sub(alu_sub), .instr_in(instr_in), .instr_out(instr_out),
        .mar_in(mar_in), .ram_in(ram_in), .ram_out(ram_out), .reg_out(reg_out),
        .pc_inc(pc_inc), .pc_out(pc_out), .pc_jmp(pc_jmp), .reg_flags_in(reg_flags_in),
        .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
        .opcode(opcode), .flags(flags), .out_value(out_value), .out_valid(out_valid),
        .bus(bus), .pc(pc), .bus_conflict(bus_conflict)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] obs(input int sel);
        case (sel)
            S_PC:    return {4'b0, pc};
            S_OPC:   return {4'b0, opcode};
            S_FLG:   return {4'b0, flags};
            S_BUS:   return bus;
            S_OUTV:  return out_value;
            S_OVLD:  return {7'b0, out_valid};
            default: return {7'b0, bus_conflict};
        endcase
    endfunction

    // monitor: drains queued expectations and scores every out_valid pulse
    initial begin
        forever begin
            @(negedge clk or posedge achk);
            if (out_valid && !achk) begin
                n_vec++;
                if (out_q.size() == 0) begin
                    n_err++;
                    $display("FAIL out_pulse: unexpected out_valid, out_value=%h", out_value);
                end else begin
                    logic [7:0] e;
                    e = out_q.pop_front();
                    if (out_value !== e) begin
                        n_err++;
                        $display("FAIL out_pulse: got %h want %h", out_value, e);
                    end
                end
            end
            while (chk_q.size() > 0) begin
                chk_t c;
                logic [7:0] a;
                c = chk_q.pop_front();
                a = obs(c.sel);
                n_vec++;
                if (a !== c.exp) begin
                    n_err++;
                    $display("FAIL %s: got %h want %h", c.name, a, c.exp);
                end
            end
        end
    end

    task automatic expect_v(input string n, input int sel, input logic [7:0] e);
        chk_t c;
        c.name = n; c.sel = sel; c.exp = e;
        chk_q.push_back(c);
    endtask

    task automatic clr();
        {halt, reg_a_in, reg_a_out, reg_b_in, reg_b_out, alu_out, alu_sub} = '0;
        {instr_in, instr_out, mar_in, ram_in, ram_out, reg_out} = '0;
        {pc_inc, pc_out, pc_jmp, prog_we} = '0;
        reg_flags_in = '0; prog_addr = '0; prog_data = '0;
    endtask

    task automatic step();
        @(posedge clk); #1;
        clr();
    endtask

    task automatic fill(input logic [7:0] v);
        for (int a = 0; a < 16; a++) begin
            prog_we = 1'b1; prog_addr = 4'(a); prog_data = v;
            step();
        end
    endtask

    task automatic ld_a(input logic [7:0] v);
        fill(v); ram_out = 1'b1; reg_a_in = 1'b1; step();
    endtask
    task automatic ld_b(input logic [7:0] v);
        fill(v); ram_out = 1'b1; reg_b_in = 1'b1; step();
    endtask
    task automatic ld_ir(input logic [7:0] v);
        fill(v); ram_out = 1'b1; instr_in = 1'b1; step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1);
    end

    initial begin
        clr();
        expect_v("rst_pc", S_PC, 8'h00);
        expect_v("rst_opc", S_OPC, 8'h00);
        expect_v("rst_flags", S_FLG, 8'h00);
        expect_v("rst_outv", S_OUTV, 8'h00);
        expect_v("rst_ovld", S_OVLD, 8'h00);
        step();
        rst = 1'b1;

        // fetch with program load
        prog_we = 1'b1; prog_addr = 4'd0;  prog_data = 8'h1E; step();
        prog_we = 1'b1; prog_addr = 4'd14; prog_data = 8'h1C; step();
        pc_out = 1'b1; mar_in = 1'b1; expect_v("fetch_bus_pc", S_BUS, 8'h00); step();
        ram_out = 1'b1; instr_in = 1'b1; pc_inc = 1'b1; expect_v("fetch_bus_ram", S_BUS, 8'h1E); step();
        expect_v("fetch_opc", S_OPC, 8'h01);
        expect_v("fetch_pc", S_PC, 8'h01);
        instr_out = 1'b1; mar_in = 1'b1; expect_v("operand_bus", S_BUS, 8'h0E); step();
        ram_out = 1'b1; reg_a_in = 1'b1; expect_v("lda_bus", S_BUS, 8'h1C); step();
        reg_a_out = 1'b1; expect_v("lda_a", S_BUS, 8'h1C); step();

        // add flags
        ld_a(8'hF0); ld_b(8'h20);
        alu_out = 1'b1; reg_a_in = 1'b1; reg_flags_in = 4'b1111;
        expect_v("add1_alu", S_BUS, 8'h10); step();
        expect_v("add1_flags", S_FLG, 8'h01);
        reg_a_out = 1'b1; expect_v("add1_a", S_BUS, 8'h10); step();
        ld_a(8'h7F); ld_b(8'h01);
        alu_out = 1'b1; reg_a_in = 1'b1; reg_flags_in = 4'b1111;
        expect_v("add2_alu", S_BUS, 8'h80); step();
        expect_v("add2_flags", S_FLG, 8'h0C);
        reg_a_out = 1'b1; expect_v("add2_a", S_BUS, 8'h80); step();

        // subtract flags
        ld_a(8'h05); ld_b(8'h05);
        alu_out = 1'b1; alu_sub = 1'b1; reg_a_in = 1'b1; reg_flags_in = 4'b1111;
        expect_v("sub1_alu", S_BUS, 8'h00); step();
        expect_v("sub1_flags", S_FLG, 8'h03);
        ld_a(8'h03);
        alu_out = 1'b1; alu_sub = 1'b1; reg_a_in = 1'b1; reg_flags_in = 4'b1111;
        expect_v("sub2_alu", S_BUS, 8'hFE); step();
        expect_v("sub2_flags", S_FLG, 8'h04);
        ld_a(8'h05);
        alu_sub = 1'b1; reg_flags_in = 4'b0001; step();
        expect_v("carry_only", S_FLG, 8'h05);

        // jump priority and wrap
        ld_ir(8'h6A);
        instr_out = 1'b1; pc_jmp = 1'b1; pc_inc = 1'b1; expect_v("jmp_bus", S_BUS, 8'h0A); step();
        expect_v("jmp_pc", S_PC, 8'h0A);
        expect_v("jmp_opc", S_OPC, 8'h06);
        ld_ir(8'h0F);
        instr_out = 1'b1; pc_jmp = 1'b1; step();
        expect_v("pc15", S_PC, 8'h0F);
        pc_inc = 1'b1; step();
        expect_v("pc_wrap", S_PC, 8'h00);

        // same-cycle mar_in + ram_in writes at the old MAR
        fill(8'h09);
        ram_out = 1'b1; mar_in = 1'b1; step();
        ram_out = 1'b1; reg_b_in = 1'b1; step();
        ld_ir(8'h03);
        fill(8'h00);
        instr_out = 1'b1; mar_in = 1'b1; ram_in = 1'b1; step();
        ram_out = 1'b1; expect_v("ram_new_mar", S_BUS, 8'h00); step();
        reg_b_out = 1'b1; mar_in = 1'b1; step();
        ram_out = 1'b1; expect_v("ram_old_mar", S_BUS, 8'h03); step();

        // output register: single pulse, then back-to-back
        fill(8'h2A);
        ram_out = 1'b1; reg_out = 1'b1; out_q.push_back(8'h2A); step();
        expect_v("out1_vld", S_OVLD, 8'h01);
        expect_v("out1_val", S_OUTV, 8'h2A);
        step();
        expect_v("out1_drop", S_OVLD, 8'h00);
        expect_v("out1_hold", S_OUTV, 8'h2A);
        pc_out = 1'b1; reg_out = 1'b1; out_q.push_back(8'h00); step();
        ram_out = 1'b1; reg_out = 1'b1; out_q.push_back(8'h2A); step();
        expect_v("b2b_vld", S_OVLD, 8'h01);
        step();
        expect_v("b2b_drop", S_OVLD, 8'h00);

        // halt freezes state
        ld_a(8'h33);
        halt = 1'b1; pc_inc = 1'b1; reg_a_in = 1'b1; reg_out = 1'b1; pc_out = 1'b1; step();
        expect_v("halt_pc", S_PC, 8'h00);
        expect_v("halt_outv", S_OUTV, 8'h2A);
        expect_v("halt_ovld", S_OVLD, 8'h00);
        reg_a_out = 1'b1; expect_v("halt_a", S_BUS, 8'h33); step();

        // bus conflict
        for (int i = 0; i < 5; i++) begin
            pc_inc = 1'b1; step();
        end
        pc_out = 1'b1; ram_out = 1'b1;
        expect_v("conf_bus", S_BUS, 8'h37);
        expect_v("conf_hi", S_CONF, 8'h01);
        step();
        ram_out = 1'b1;
        expect_v("conf_lo", S_CONF, 8'h00);
        step();

        // asynchronous reset mid-operation
        ld_ir(8'h97);
        instr_out = 1'b1; pc_jmp = 1'b1; step();
        expect_v("pre_rst_pc", S_PC, 8'h07);
        ld_a(8'h55);
        ram_out = 1'b1; reg_out = 1'b1; out_q.push_back(8'h55); step();
        expect_v("pre_rst_outv", S_OUTV, 8'h55);
        prog_we = 1'b1; prog_addr = 4'd0; prog_data = 8'h1E; step();
        reg_a_out = 1'b1;
        #1 rst = 1'b0;
        #1;
        expect_v("arst_pc", S_PC, 8'h00);
        expect_v("arst_a", S_BUS, 8'h00);
        expect_v("arst_opc", S_OPC, 8'h00);
        expect_v("arst_flags", S_FLG, 8'h00);
        expect_v("arst_outv", S_OUTV, 8'h00);
        expect_v("arst_ovld", S_OVLD, 8'h00);
        achk = 1'b1;
        #1 achk = 1'b0;
        step();
        rst = 1'b1;
        ram_out = 1'b1; expect_v("ram_kept", S_BUS, 8'h1E); step();

        @(negedge clk); #1;
        n_vec++;
        if (chk_q.size() != 0) begin
            n_err++;
            $display("FAIL chk_drain: got %0d pending want 0", chk_q.size());
        end
        n_vec++;
        if (out_q.size() != 0) begin
            n_err++;
            $display("FAIL out_drain: got %0d pending want 0", out_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
